ins_loader: RTL and testbench

//  Host-side instruction encoder/loader; the write end of the instruction-memory interface the decoder reads.

---
 rtl/ins_loader.sv | 98 +++++++++
 tb/tb_ins_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ins_loader.sv
// Host-side instruction loader: packs streamed instruction fields into words,
// writes them to instruction memory, pads the rest with NOPs, then releases the processor.
module ins_loader #(
  parameter int OPCODE_WIDTH   = 3,
  parameter int ADDR_WIDTH     = 10,
  parameter int INS_ADDR_WIDTH = 10
) (
  input  logic                                       clk,
  input  logic                                       rstn,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [OPCODE_WIDTH-1:0]                    in_opcode,
  input  logic [ADDR_WIDTH-1:0]                      in_a_addr,
  input  logic [ADDR_WIDTH-1:0]                      in_b_addr,
  input  logic [ADDR_WIDTH-1:0]                      in_r_addr,
  input  logic                                       in_last,
  input  logic                                       run_stop,
  output logic                                       ins_we,
  output logic [INS_ADDR_WIDTH-1:0]                  ins_waddr,
  output logic [OPCODE_WIDTH+3*ADDR_WIDTH-1:0]       ins_wdata,
  output logic                                       proc_rstn,
  output logic [INS_ADDR_WIDTH:0]                    loaded_count,
  output logic                                       full
);

  localparam int INS_WIDTH = OPCODE_WIDTH + 3*ADDR_WIDTH;
  localparam logic [INS_ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, LOAD, FILL, RUN} state_t;

  state_t                    state, state_nxt;
  logic [INS_ADDR_WIDTH-1:0] ptr;
  logic                      accept;
  logic [INS_WIDTH-1:0]      encoded;

  assign accept  = in_valid & in_ready;
  assign encoded = {in_a_addr, in_b_addr, in_r_addr, in_opcode};

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, LOAD: begin
        if (accept) begin
          if (ptr == LAST_ADDR) state_nxt = RUN;
          else if (in_last)     state_nxt = FILL;
          else                  state_nxt = LOAD;
        end
      end
      FILL:    if (ptr == LAST_ADDR) state_nxt = RUN;
      RUN:     if (run_stop)         state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) || (state == LOAD);
  end

  // Write port and bookkeeping; proc_rstn is taken from the registered state so it
  // rises one cycle after the final write is presented on the bus.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ins_we       <= 1'b0;
      ins_waddr    <= '0;
      ins_wdata    <= '0;
      proc_rstn    <= 1'b0;
      loaded_count <= '0;
      full         <= 1'b0;
      ptr          <= '0;
    end else begin
      ins_we    <= 1'b0;
      proc_rstn <= (state == RUN) && !run_stop;
      if (accept) begin
        ins_we       <= 1'b1;
        ins_waddr    <= ptr;
        ins_wdata    <= encoded;
        ptr          <= ptr + 1'b1;
        loaded_count <= loaded_count + 1'b1;
        if (ptr == LAST_ADDR) full <= 1'b1;
      end else if (state == FILL) begin
        ins_we    <= 1'b1;
        ins_waddr <= ptr;
        ins_wdata <= '0;
        ptr       <= ptr + 1'b1;
      end else if (state == RUN && run_stop) begin
        ptr          <= '0;
        loaded_count <= '0;
        full         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ins_loader.sv
// Randomized bench for ins_loader: each program's expected memory image is built up front
// and every observed write, status output and release timing is checked against it.
module tb_ins_loader;

  localparam int OW    = 3;
  localparam int AW    = 10;
  localparam int IAW   = 10;
  localparam int IW    = OW + 3*AW;
  localparam int DEPTH = 2**IAW;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [OW-1:0]  in_opcode = '0;
  logic [AW-1:0]  in_a_addr = '0;
  logic [AW-1:0]  in_b_addr = '0;
  logic [AW-1:0]  in_r_addr = '0;
  logic           in_last = 1'b0;
  logic           run_stop = 1'b0;
  logic           ins_we;
  logic [IAW-1:0] ins_waddr;
  logic [IW-1:0]  ins_wdata;
  logic           proc_rstn;
  logic [IAW:0]   loaded_count;
  logic           full;

  int errors = 0;
  int checks = 0;

  logic [IW-1:0] exp_mem [DEPTH];
  logic [OW-1:0] p_op [DEPTH];
  logic [AW-1:0] p_a  [DEPTH];
  logic [AW-1:0] p_b  [DEPTH];
  logic [AW-1:0] p_r  [DEPTH];

  ins_loader #(
    .OPCODE_WIDTH  (OW),
    .ADDR_WIDTH    (AW),
    .INS_ADDR_WIDTH(IAW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_a_addr   (in_a_addr),
    .in_b_addr   (in_b_addr),
    .in_r_addr   (in_r_addr),
    .in_last     (in_last),
    .run_stop    (run_stop),
    .ins_we      (ins_we),
    .ins_waddr   (ins_waddr),
    .ins_wdata   (ins_wdata),
    .proc_rstn   (proc_rstn),
    .loaded_count(loaded_count),
    .full        (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  in_ready, 1);
    check({tag, "_ins_we"},    ins_we, 0);
    check({tag, "_ins_waddr"}, ins_waddr, 0);
    check({tag, "_ins_wdata"}, ins_wdata, 0);
    check({tag, "_proc_rstn"}, proc_rstn, 0);
    check({tag, "_count"},     loaded_count, 0);
    check({tag, "_full"},      full, 0);
  endtask

  task automatic do_reset(input int cycles);
    rstn     = 1'b0;
    in_valid = 1'b0;
    run_stop = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    check_reset_values("reset");
    rstn = 1'b1;
  endtask

  task automatic do_stop();
    run_stop = 1'b1;
    @(posedge clk); #1;
    run_stop = 1'b0;
    check("stop_proc_rstn", proc_rstn, 0);
    check("stop_in_ready",  in_ready, 1);
    check("stop_count",     loaded_count, 0);
    check("stop_full",      full, 0);
    check("stop_we",        ins_we, 0);
  endtask

  // n instructions; last flag on the final one unless the program fills memory.
  // abort_at != 0 returns after that many cycles without the release checks.
  task automatic run_program(input int n, input bit gaps, input bit hold, input int abort_at);
    int acc = 0;
    int wr = 0;
    int cyc = 0;
    bit fill_phase = 1'b0;
    bit accepted;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    for (int i = 0; i < n; i++) begin
      p_op[i] = OW'($urandom);
      p_a[i]  = AW'($urandom);
      p_b[i]  = AW'($urandom);
      p_r[i]  = AW'($urandom);
      exp_mem[i] = {p_a[i], p_b[i], p_r[i], p_op[i]};
    end
    while (wr < DEPTH) begin
      if (abort_at != 0 && cyc == abort_at) return;
      if (cyc >= 4*DEPTH) begin
        check("timeout_writes", wr, DEPTH);
        return;
      end
      check("in_ready", in_ready, (acc < n) ? 1 : 0);
      if (acc < n) begin
        in_valid  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_opcode = p_op[acc];
        in_a_addr = p_a[acc];
        in_b_addr = p_b[acc];
        in_r_addr = p_r[acc];
        in_last   = (acc == n-1) && (n < DEPTH);
      end else begin
        in_valid  = hold;
        in_last   = hold;
      end
      run_stop = ($urandom_range(0, 7) == 0);
      accepted = in_valid && (acc < n);
      @(posedge clk); #1;
      cyc++;
      if (accepted) acc++;
      check("loaded_count", loaded_count, acc);
      check("proc_rstn_held", proc_rstn, 0);
      if (accepted || fill_phase) begin
        check("ins_we", ins_we, 1);
        check("ins_waddr", ins_waddr, wr);
        check("ins_wdata", ins_wdata, exp_mem[wr]);
        wr++;
      end else begin
        check("ins_we_quiet", ins_we, 0);
      end
      if (accepted && acc == n) fill_phase = 1'b1;
    end
    run_stop = 1'b0;
    in_valid = hold;
    check("full_flag", full, (n == DEPTH) ? 1 : 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("run_proc_rstn", proc_rstn, 1);
      check("run_we", ins_we, 0);
      check("run_in_ready", in_ready, 0);
      check("run_count", loaded_count, n);
      check("run_full", full, (n == DEPTH) ? 1 : 0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    do_reset(2);

    // Directed encode: ADD a=1 b=2 r=3
    in_valid  = 1'b1;
    in_opcode = 3'b001;
    in_a_addr = 10'd1;
    in_b_addr = 10'd2;
    in_r_addr = 10'd3;
    in_last   = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("enc_we",    ins_we, 1);
    check("enc_waddr", ins_waddr, 0);
    check("enc_wdata", ins_wdata, 33'h0_0080_4019);
    check("enc_count", loaded_count, 1);
    check("enc_proc_rstn", proc_rstn, 0);
    @(posedge clk); #1;
    check("enc_we_drop", ins_we, 0);
    do_reset(1);

    run_program(3, 1'b0, 1'b1, 0);
    do_stop();
    run_program($urandom_range(1, 40), 1'b1, 1'b0, 0);
    do_stop();
    run_program(DEPTH, 1'b0, 1'b1, 0);
    do_stop();
    run_program(DEPTH - 1, 1'b0, 1'b0, 0);
    do_stop();

    // Reset pulse in the middle of NOP padding
    run_program(5, 1'b0, 1'b1, 20);
    rstn     = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_reset_values("midfill");
    rstn = 1'b1;
    run_program(2, 1'b1, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
